// File: rtl/tetris_pkg.sv
// Shared encodings for the falling-piece datapath: move commands, board size
// and the move controller state encoding.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_LEFT   = 3'd0,
        CMD_RIGHT  = 3'd1,
        CMD_DOWN   = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_DROP   = 3'd4
    } move_cmd_e;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DECIDE = 2'd2
    } state_e;

endpackage

// File: rtl/piece_rotator.sv
// Clockwise rotation of a 4x4 row-major shape (index 0 is the top-left cell):
// new[4r+c] = old[4(3-c)+r].
module piece_rotator (
    input  logic [0:15] float_i,
    output logic [0:15] float_o
);

    always_comb begin
        float_o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                float_o[4*r+c] = float_i[4*(3-c)+r];
            end
        end
    end

endmodule

// File: rtl/piece_move_controller.sv
// Piece move controller: builds candidate positions for spawn/move commands,
// hands them to an external collision checker and commits or rejects them.
module piece_move_controller
    import tetris_pkg::*;
#(
    parameter int CHECK_LATENCY = 1,
    parameter int DROP_MAX      = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spawn_valid,
    output logic        spawn_ready,
    input  logic [3:0]  spawn_x,
    input  logic [4:0]  spawn_y,
    input  logic [0:15] spawn_float,
    input  logic        move_valid,
    input  logic [2:0]  move_cmd,
    output logic        move_ready,
    output logic        move_done,
    output logic        move_ok,
    output logic        lock,
    output logic        game_over,
    output logic [3:0]  chk_x,
    output logic [4:0]  chk_y,
    output logic [0:15] chk_float,
    input  logic        chk_collision,
    output logic [3:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [0:15] cur_float,
    output logic        piece_active
);

    localparam int LAT_W  = (CHECK_LATENCY > 1) ? $clog2(CHECK_LATENCY) : 1;
    localparam int STEP_W = $clog2(DROP_MAX + 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(CHECK_LATENCY - 1);
    localparam logic [LAT_W-1:0]  LAT_ONE   = LAT_W'(1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DROP_MAX - 1);
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);

    state_e             state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic               spawn_q, spawn_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [3:0]         cur_x_q, cur_x_d, chk_x_q, chk_x_d;
    logic [4:0]         cur_y_q, cur_y_d, chk_y_q, chk_y_d;
    logic [0:15]        cur_float_q, cur_float_d, chk_float_q, chk_float_d;
    logic               active_q, active_d, over_q, over_d;
    logic               done_q, done_d, ok_q, ok_d, lock_q, lock_d;
    logic               reject;
    logic [0:15]        rot_float;

    piece_rotator u_rot (
        .float_i (cur_float_q),
        .float_o (rot_float)
    );

    assign spawn_ready = (state_q == ST_IDLE) && !over_q;
    assign move_ready  = (state_q == ST_IDLE) && active_q && !over_q;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        spawn_d     = spawn_q;
        lat_d       = lat_q;
        steps_d     = steps_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cur_float_d = cur_float_q;
        chk_x_d     = chk_x_q;
        chk_y_d     = chk_y_q;
        chk_float_d = chk_float_q;
        active_d    = active_q;
        over_d      = over_q;
        done_d      = 1'b0;
        ok_d        = 1'b0;
        lock_d      = 1'b0;
        reject      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (spawn_valid && spawn_ready) begin
                    chk_x_d     = spawn_x;
                    chk_y_d     = spawn_y;
                    chk_float_d = spawn_float;
                    spawn_d     = 1'b1;
                    lat_d       = '0;
                    state_d     = ST_CHECK;
                end else if (move_valid && move_ready) begin
                    spawn_d     = 1'b0;
                    cmd_d       = move_cmd;
                    steps_d     = '0;
                    lat_d       = '0;
                    chk_x_d     = cur_x_q;
                    chk_y_d     = cur_y_q;
                    chk_float_d = cur_float_q;
                    state_d     = ST_CHECK;
                    case (move_cmd)
                        CMD_LEFT:   if (cur_x_q == 4'd0) reject = 1'b1;
                                    else chk_x_d = cur_x_q - 4'd1;
                        CMD_RIGHT:  chk_x_d = cur_x_q + 4'd1;
                        CMD_DOWN,
                        CMD_DROP:   if (cur_y_q == 5'd31) reject = 1'b1;
                                    else chk_y_d = cur_y_q + 5'd1;
                        CMD_ROTATE: chk_float_d = rot_float;
                        default:    reject = 1'b1;
                    endcase
                    // Local rejects complete next cycle without touching the checker.
                    if (reject) begin
                        chk_x_d     = chk_x_q;
                        chk_y_d     = chk_y_q;
                        chk_float_d = chk_float_q;
                        state_d     = ST_IDLE;
                        done_d      = 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (lat_q == LAT_LAST) state_d = ST_DECIDE;
                else                   lat_d   = lat_q + LAT_ONE;
            end
            ST_DECIDE: begin
                state_d = ST_IDLE;
                lat_d   = '0;
                if (spawn_q) begin
                    if (chk_collision) begin
                        over_d   = 1'b1;
                        active_d = 1'b0;
                    end else begin
                        cur_x_d     = chk_x_q;
                        cur_y_d     = chk_y_q;
                        cur_float_d = chk_float_q;
                        active_d    = 1'b1;
                    end
                end else if (!chk_collision) begin
                    cur_x_d     = chk_x_q;
                    cur_y_d     = chk_y_q;
                    cur_float_d = chk_float_q;
                    if (cmd_q == CMD_DROP && steps_q != STEP_LAST) begin
                        steps_d = steps_q + STEP_ONE;
                        chk_y_d = chk_y_q + 5'd1;
                        state_d = ST_CHECK;
                    end else begin
                        done_d = 1'b1;
                        ok_d   = 1'b1;
                    end
                end else begin
                    done_d = 1'b1;
                    if (cmd_q == CMD_DOWN || cmd_q == CMD_DROP) begin
                        lock_d   = 1'b1;
                        active_d = 1'b0;
                        ok_d     = (cmd_q == CMD_DROP) && (steps_q != '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            spawn_q     <= 1'b0;
            lat_q       <= '0;
            steps_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            cur_float_q <= '0;
            chk_x_q     <= '0;
            chk_y_q     <= '0;
            chk_float_q <= '0;
            active_q    <= 1'b0;
            over_q      <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
            lock_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            spawn_q     <= spawn_d;
            lat_q       <= lat_d;
            steps_q     <= steps_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cur_float_q <= cur_float_d;
            chk_x_q     <= chk_x_d;
            chk_y_q     <= chk_y_d;
            chk_float_q <= chk_float_d;
            active_q    <= active_d;
            over_q      <= over_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
            lock_q      <= lock_d;
        end
    end

    assign move_done    = done_q;
    assign move_ok      = ok_q;
    assign lock         = lock_q;
    assign game_over    = over_q;
    assign chk_x        = chk_x_q;
    assign chk_y        = chk_y_q;
    assign chk_float    = chk_float_q;
    assign cur_x        = cur_x_q;
    assign cur_y        = cur_y_q;
    assign cur_float    = cur_float_q;
    assign piece_active = active_q;

endmodule

// File: tb/tb_piece_move_controller.sv
// Directed bench for piece_move_controller with a simple board-limit collision model.
module tb_piece_move_controller;
    import tetris_pkg::*;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        spawn_valid, spawn_ready;
    logic [3:0]  spawn_x;
    logic [4:0]  spawn_y;
    logic [0:15] spawn_float;
    logic        move_valid, move_ready, move_done, move_ok, lock, game_over;
    logic [2:0]  move_cmd;
    logic [3:0]  chk_x, cur_x;
    logic [4:0]  chk_y, cur_y;
    logic [0:15] chk_float, cur_float;
    logic        chk_collision, piece_active;

    logic        coll_force;
    logic [5:0]  coll_y;
    int          pass_cnt = 0;
    int          total    = 0;
    int          done_cnt = 0;

    piece_move_controller #(.CHECK_LATENCY(LAT), .DROP_MAX(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_float(spawn_float),
        .move_valid(move_valid), .move_cmd(move_cmd), .move_ready(move_ready),
        .move_done(move_done), .move_ok(move_ok), .lock(lock), .game_over(game_over),
        .chk_x(chk_x), .chk_y(chk_y), .chk_float(chk_float), .chk_collision(chk_collision),
        .cur_x(cur_x), .cur_y(cur_y), .cur_float(cur_float), .piece_active(piece_active)
    );

    always #5 clk = ~clk;

    // Collision: forced, below the floor limit, or past the right wall.
    assign chk_collision = coll_force | ({1'b0, chk_y} >= coll_y) | (chk_x >= 4'd10);

    always @(posedge move_done) done_cnt++;

    typedef struct {
        logic [2:0]  cmd;
        int          lat;
        logic        ok;
        logic        lk;
        logic [3:0]  x;
        logic [4:0]  y;
        logic [15:0] f;
        logic        act;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        total++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic do_spawn(input logic [3:0] x, input logic [4:0] y, input logic [15:0] f);
        int n;
        int dc;
        n = 0;
        while (!spawn_ready && n < 50) begin @(negedge clk); n++; end
        if (!spawn_ready) timeout("spawn_ready");
        dc = done_cnt;
        spawn_valid = 1'b1; spawn_x = x; spawn_y = y; spawn_float = f;
        @(posedge clk); #1 spawn_valid = 1'b0;
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("spawn_no_done", done_cnt, dc);
    endtask

    task automatic do_move(input logic [2:0] cmd, output int lat, output logic ok,
                           output logic lk, output logic got);
        int n;
        got = 1'b0; lat = 0; ok = 1'b0; lk = 1'b0;
        n = 0;
        while (!move_ready && n < 50) begin @(negedge clk); n++; end
        if (!move_ready) begin
            timeout("move_ready");
            return;
        end
        move_valid = 1'b1; move_cmd = cmd;
        @(posedge clk); #1 move_valid = 1'b0;
        lat = 1;
        forever begin
            @(negedge clk);
            if (move_done) break;
            if (lat > 200) break;
            @(posedge clk);
            lat++;
        end
        if (!move_done) begin
            timeout("move_done");
            return;
        end
        got = 1'b1; ok = move_ok; lk = lock;
    endtask

    initial begin
        int lat;
        logic ok, lk, got;
        int dc;
        logic [3:0] sx;
        logic [4:0] sy;
        logic [0:15] sf;

        vecs[0]  = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd4, 5'd0,  16'h0F00, 1'b1};
        vecs[1]  = '{CMD_LEFT,   3, 1'b1, 1'b0, 4'd3, 5'd0,  16'h0F00, 1'b1};
        vecs[2]  = '{CMD_ROTATE, 3, 1'b1, 1'b0, 4'd3, 5'd0,  16'h2222, 1'b1};
        vecs[3]  = '{CMD_DOWN,   3, 1'b1, 1'b0, 4'd3, 5'd1,  16'h2222, 1'b1};
        vecs[4]  = '{3'd5,       1, 1'b0, 1'b0, 4'd3, 5'd1,  16'h2222, 1'b1};
        vecs[5]  = '{3'd7,       1, 1'b0, 1'b0, 4'd3, 5'd1,  16'h2222, 1'b1};
        vecs[6]  = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd4, 5'd1,  16'h2222, 1'b1};
        vecs[7]  = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd5, 5'd1,  16'h2222, 1'b1};
        vecs[8]  = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd6, 5'd1,  16'h2222, 1'b1};
        vecs[9]  = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd7, 5'd1,  16'h2222, 1'b1};
        vecs[10] = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd8, 5'd1,  16'h2222, 1'b1};
        vecs[11] = '{CMD_RIGHT,  3, 1'b1, 1'b0, 4'd9, 5'd1,  16'h2222, 1'b1};
        vecs[12] = '{CMD_RIGHT,  3, 1'b0, 1'b0, 4'd9, 5'd1,  16'h2222, 1'b1};
        vecs[13] = '{CMD_ROTATE, 3, 1'b1, 1'b0, 4'd9, 5'd1,  16'h00F0, 1'b1};
        vecs[14] = '{CMD_DROP,  39, 1'b1, 1'b1, 4'd9, 5'd19, 16'h00F0, 1'b0};

        rst_n = 1'b0; spawn_valid = 1'b0; move_valid = 1'b0; move_cmd = '0;
        spawn_x = '0; spawn_y = '0; spawn_float = '0;
        coll_force = 1'b0; coll_y = 6'd20;
        repeat (3) @(negedge clk);
        check("rst_cur_x", cur_x, 0);
        check("rst_cur_y", cur_y, 0);
        check("rst_cur_float", cur_float, 0);
        check("rst_chk", {chk_x, chk_y, chk_float}, 0);
        check("rst_active", piece_active, 0);
        check("rst_game_over", game_over, 0);
        check("rst_pulses", {move_done, move_ok, lock}, 0);
        check("rst_move_ready", move_ready, 0);
        check("rst_spawn_ready", spawn_ready, 1);
        rst_n = 1'b1;

        do_spawn(4'd3, 5'd0, 16'h0F00);
        check("spawn_active", piece_active, 1);
        check("spawn_cur", {cur_x, cur_y, cur_float}, {4'd3, 5'd0, 16'h0F00});

        for (int i = 0; i < 15; i++) begin
            do_move(vecs[i].cmd, lat, ok, lk, got);
            if (got) begin
                check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
                check($sformatf("v%0d_ok", i), ok, vecs[i].ok);
                check($sformatf("v%0d_lock", i), lk, vecs[i].lk);
                check($sformatf("v%0d_cur", i), {cur_x, cur_y, cur_float},
                      {vecs[i].x, vecs[i].y, vecs[i].f});
                check($sformatf("v%0d_active", i), piece_active, vecs[i].act);
            end
        end
        check("locked_move_ready", move_ready, 0);

        // LEFT at the left wall is rejected locally.
        do_spawn(4'd0, 5'd5, 16'hF000);
        sx = chk_x; sy = chk_y; sf = chk_float;
        do_move(CMD_LEFT, lat, ok, lk, got);
        check("left0_lat", lat, 1);
        check("left0_ok", ok, 0);
        check("left0_chk", {chk_x, chk_y, chk_float}, {sx, sy, sf});
        check("left0_cur_x", cur_x, 0);

        // Spawn wins over a simultaneous move.
        dc = done_cnt;
        spawn_valid = 1'b1; spawn_x = 4'd6; spawn_y = 5'd2; spawn_float = 16'h0F00;
        move_valid = 1'b1; move_cmd = CMD_RIGHT;
        @(posedge clk); #1 spawn_valid = 1'b0; move_valid = 1'b0;
        check("prio_chk_x", chk_x, 6);
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("prio_cur", {cur_x, cur_y}, {4'd6, 5'd2});
        check("prio_no_done", done_cnt, dc);

        // DOWN / DROP at the bottom row are rejected locally.
        coll_y = 6'd32;
        do_spawn(4'd2, 5'd31, 16'h0F00);
        do_move(CMD_DOWN, lat, ok, lk, got);
        check("down31_lat", lat, 1);
        check("down31_res", {ok, lk, cur_y}, {1'b0, 1'b0, 5'd31});
        do_move(CMD_DROP, lat, ok, lk, got);
        check("drop31_lat", lat, 1);
        check("drop31_res", {ok, lk, piece_active}, {1'b0, 1'b0, 1'b1});

        // DROP runs out of steps without hitting anything.
        do_spawn(4'd3, 5'd0, 16'h0F00);
        do_move(CMD_DROP, lat, ok, lk, got);
        check("dropmax_lat", lat, 41);
        check("dropmax_res", {ok, lk, piece_active, cur_y}, {1'b1, 1'b0, 1'b1, 5'd20});

        // DROP collides at candidate y=5.
        coll_y = 6'd5;
        do_spawn(4'd3, 5'd0, 16'h0F00);
        do_move(CMD_DROP, lat, ok, lk, got);
        check("drop5_lat", lat, 11);
        check("drop5_res", {ok, lk, piece_active, cur_y}, {1'b1, 1'b1, 1'b0, 5'd4});

        // DROP blocked on its very first step.
        coll_y = 6'd4;
        do_spawn(4'd3, 5'd3, 16'h0F00);
        do_move(CMD_DROP, lat, ok, lk, got);
        check("drop0_lat", lat, 3);
        check("drop0_res", {ok, lk, piece_active, cur_y}, {1'b0, 1'b1, 1'b0, 5'd3});

        // Reset in the middle of a DROP.
        coll_y = 6'd32;
        do_spawn(4'd3, 5'd0, 16'h0F00);
        dc = done_cnt;
        move_valid = 1'b1; move_cmd = CMD_DROP;
        @(posedge clk); #1 move_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_cur", {cur_x, cur_y, cur_float}, 0);
        check("midrst_chk", {chk_x, chk_y, chk_float}, 0);
        check("midrst_flags", {piece_active, game_over, move_done, move_ok, lock}, 0);
        repeat (3) @(negedge clk);
        check("midrst_no_done", done_cnt, dc);
        rst_n = 1'b1;
        spawn_valid = 1'b1; spawn_x = 4'd5; spawn_y = 5'd2; spawn_float = 16'hF000;
        @(posedge clk); #1 spawn_valid = 1'b0;
        check("post_rst_accept", {chk_x, chk_y}, {4'd5, 5'd2});
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        check("post_rst_spawn", {piece_active, cur_x, cur_y}, {1'b1, 4'd5, 5'd2});

        // Spawn into a collision ends the game.
        coll_force = 1'b1;
        do_spawn(4'd1, 5'd0, 16'hF000);
        check("go_flag", game_over, 1);
        check("go_state", {piece_active, spawn_ready, move_ready, cur_x}, {1'b0, 1'b0, 1'b0, 4'd5});
        coll_force = 1'b0;
        dc = done_cnt;
        spawn_valid = 1'b1; spawn_x = 4'd7; move_valid = 1'b1; move_cmd = CMD_RIGHT;
        repeat (5) @(negedge clk);
        spawn_valid = 1'b0; move_valid = 1'b0;
        check("go_ignored", {chk_x, game_over, piece_active}, {4'd1, 1'b1, 1'b0});
        check("go_no_done", done_cnt, dc);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
